demux_ctrl: RTL and testbench

DEMUX_CTRL -- requirements
Module: demux_ctrl

---
 rtl/demux_ctrl_pkg.sv | 15 +
 rtl/demux_ctrl_demux.sv | 24 ++
 rtl/demux_ctrl.sv | 113 +++++++++++
 tb/tb_demux_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the demux_ctrl block.
//   state_t   : controller states (IDLE, HOLD_A, HOLD_B)
//   CH_A/CH_B : channel encodings used for sel and destination
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/demux_ctrl_demux.sv
// One-to-two data demultiplexer; the unselected output is driven to zero.
//   i     : input word
//   sel   : CH_A routes to out_a, CH_B routes to out_b
//   out_a : channel A data
//   out_b : channel B data
module demux_ctrl_demux
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned bit_width = 8
) (
  input  logic [bit_width-1:0] i,
  input  logic                 sel,
  output logic [bit_width-1:0] out_a,
  output logic [bit_width-1:0] out_b
);

  always_comb begin
    out_a = '0;
    out_b = '0;
    if (sel == CH_B) out_b = i;
    else             out_a = i;
  end

endmodule

// File: rtl/demux_ctrl.sv
// Single-entry steering buffer: accepts one word and presents it on channel
// A or B (tag or round-robin policy), counting completed transfers per channel.
//   clk, rst                  : clock, synchronous active-high reset
//   i, i_valid, i_ready       : input handshake
//   i_dest, mode              : tag destination, policy (0=tag, 1=round-robin)
//   out_a/out_b (+valid/ready): channel handshakes
//   sel                       : channel of held word (0 when idle)
//   cnt_a, cnt_b              : wrapping completed-transfer counters
module demux_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned bit_width = 8,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [bit_width-1:0] i,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_dest,
  input  logic                 mode,
  output logic [bit_width-1:0] out_a,
  output logic [bit_width-1:0] out_b,
  output logic                 out_a_valid,
  output logic                 out_b_valid,
  input  logic                 out_a_ready,
  input  logic                 out_b_ready,
  output logic                 sel,
  output logic [cnt_width-1:0] cnt_a,
  output logic [cnt_width-1:0] cnt_b
);

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [bit_width-1:0]   data_q, data_d;
  logic [cnt_width-1:0]   cnt_a_q, cnt_a_d;
  logic [cnt_width-1:0]   cnt_b_q, cnt_b_d;

  logic                   hold_a, hold_b;
  logic                   drain_a, drain_b;
  logic                   accept;
  logic                   dest;
  logic [bit_width-1:0]   dmx_a, dmx_b;

  // Handshake decode; drain and refill may happen in the same cycle.
  always_comb begin
    hold_a  = (state_q == HOLD_A);
    hold_b  = (state_q == HOLD_B);
    drain_a = hold_a && out_a_ready;
    drain_b = hold_b && out_b_ready;
    i_ready = !rst && ((state_q == IDLE) || drain_a || drain_b);
    accept  = i_valid && i_ready;
    dest    = mode ? rr_q : i_dest;
  end

  // Next-state, holding register, round-robin pointer and counters.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    data_d  = data_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;

    if (drain_a) cnt_a_d = cnt_a_q + cnt_width'(1);
    if (drain_b) cnt_b_d = cnt_b_q + cnt_width'(1);

    if (drain_a || drain_b) state_d = IDLE;

    if (accept) begin
      state_d = (dest == CH_B) ? HOLD_B : HOLD_A;
      data_d  = i;
      if (mode) rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      data_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  demux_ctrl_demux #(
    .bit_width(bit_width)
  ) u_demux (
    .i    (data_q),
    .sel  (hold_b),
    .out_a(dmx_a),
    .out_b(dmx_b)
  );

  // Outputs are masked while reset is asserted so nothing leaks before the
  // first reset edge has cleared the state register.
  always_comb begin
    out_a_valid = hold_a && !rst;
    out_b_valid = hold_b && !rst;
    sel         = out_b_valid;
    out_a       = out_a_valid ? dmx_a : '0;
    out_b       = out_b_valid ? dmx_b : '0;
    cnt_a       = cnt_a_q;
    cnt_b       = cnt_b_q;
  end

endmodule

// File: tb/tb_demux_ctrl.sv
// Directed, table-driven bench for demux_ctrl. A second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_demux_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i;
  logic       i_valid, i_dest, mode, out_a_ready, out_b_ready;

  logic        i_ready, out_a_valid, out_b_valid, sel;
  logic [7:0]  out_a, out_b;
  logic [15:0] cnt_a, cnt_b;

  logic        i_ready4, out_a_valid4, out_b_valid4, sel4;
  logic [7:0]  out_a4, out_b4;
  logic [3:0]  cnt_a4, cnt_b4;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_ctrl dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .i_dest(i_dest), .mode(mode), .out_a(out_a), .out_b(out_b),
    .out_a_valid(out_a_valid), .out_b_valid(out_b_valid),
    .out_a_ready(out_a_ready), .out_b_ready(out_b_ready),
    .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  demux_ctrl #(.bit_width(8), .cnt_width(4)) dut4 (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready4),
    .i_dest(i_dest), .mode(mode), .out_a(out_a4), .out_b(out_b4),
    .out_a_valid(out_a_valid4), .out_b_valid(out_b_valid4),
    .out_a_ready(out_a_ready), .out_b_ready(out_b_ready),
    .sel(sel4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  typedef struct packed {
    logic        rst, iv;
    logic [7:0]  d;
    logic        dst, md, ar, br;
    logic        rdy, av, bv;
    logic [7:0]  a, b;
    logic        sel;
    logic [15:0] ca, cb;
  } vec_t;

  function automatic vec_t mkv(logic r, logic iv, logic [7:0] d, logic dst,
                               logic md, logic ar, logic br, logic rdy,
                               logic av, logic bv, logic [7:0] a,
                               logic [7:0] b, logic s, logic [15:0] ca,
                               logic [15:0] cb);
    vec_t v;
    v.rst = r;  v.iv = iv; v.d = d; v.dst = dst; v.md = md; v.ar = ar;
    v.br = br;  v.rdy = rdy; v.av = av; v.bv = bv; v.a = a; v.b = b;
    v.sel = s;  v.ca = ca; v.cb = cb;
    return v;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; i_valid = v.iv; i = v.d; i_dest = v.dst; mode = v.md;
    out_a_ready = v.ar; out_b_ready = v.br;
  endtask

  task automatic check(input string tag, input vec_t v);
    applied++;
    chk(tag, "i_ready",     16'(i_ready),      16'(v.rdy));
    chk(tag, "out_a_valid", 16'(out_a_valid),  16'(v.av));
    chk(tag, "out_b_valid", 16'(out_b_valid),  16'(v.bv));
    chk(tag, "out_a",       16'(out_a),        16'(v.a));
    chk(tag, "out_b",       16'(out_b),        16'(v.b));
    chk(tag, "sel",         16'(sel),          16'(v.sel));
    chk(tag, "cnt_a",       cnt_a,             v.ca);
    chk(tag, "cnt_b",       cnt_b,             v.cb);
    chk(tag, "w4 i_ready",  16'(i_ready4),     16'(v.rdy));
    chk(tag, "w4 a_valid",  16'(out_a_valid4), 16'(v.av));
    chk(tag, "w4 b_valid",  16'(out_b_valid4), 16'(v.bv));
    chk(tag, "w4 out_a",    16'(out_a4),       16'(v.a));
    chk(tag, "w4 out_b",    16'(out_b4),       16'(v.b));
    chk(tag, "w4 sel",      16'(sel4),         16'(v.sel));
    chk(tag, "w4 cnt_a",    16'(cnt_a4),       16'(v.ca[3:0]));
    chk(tag, "w4 cnt_b",    16'(cnt_b4),       16'(v.cb[3:0]));
  endtask

  vec_t tv[27];

  initial begin
    // Each vector: inputs driven for one cycle; expected outputs are those
    // observed before that cycle's rising edge. Counters are cumulative.
    //             rst iv d     dst md ar br  rdy av bv a      b      s  ca cb
    tv[0]  = mkv(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    // tag mode back-to-back A then B
    tv[1]  = mkv(0, 1, 8'h10, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tv[2]  = mkv(0, 1, 8'h20, 1, 0, 1, 1,  1, 1, 0, 8'h10, 8'h00, 0, 0, 0);
    tv[3]  = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 1, 8'h00, 8'h20, 1, 1, 0);
    tv[4]  = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 1, 1);
    // round-robin, i_dest=1 ignored: A,B,A,B
    tv[5]  = mkv(0, 1, 8'h01, 1, 1, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 1, 1);
    tv[6]  = mkv(0, 1, 8'h02, 1, 1, 1, 1,  1, 1, 0, 8'h01, 8'h00, 0, 1, 1);
    tv[7]  = mkv(0, 1, 8'h03, 1, 1, 1, 1,  1, 0, 1, 8'h00, 8'h02, 1, 2, 1);
    tv[8]  = mkv(0, 1, 8'h04, 1, 1, 1, 1,  1, 1, 0, 8'h03, 8'h00, 0, 2, 2);
    tv[9]  = mkv(0, 0, 8'h00, 1, 1, 1, 1,  1, 0, 1, 8'h00, 8'h04, 1, 3, 2);
    tv[10] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 3, 3);
    // backpressure on A for three cycles
    tv[11] = mkv(0, 1, 8'h55, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 3, 3);
    tv[12] = mkv(0, 1, 8'h66, 1, 0, 0, 1,  0, 1, 0, 8'h55, 8'h00, 0, 3, 3);
    tv[13] = mkv(0, 1, 8'h66, 1, 0, 0, 1,  0, 1, 0, 8'h55, 8'h00, 0, 3, 3);
    tv[14] = mkv(0, 1, 8'h66, 1, 0, 0, 1,  0, 1, 0, 8'h55, 8'h00, 0, 3, 3);
    tv[15] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 1, 0, 8'h55, 8'h00, 0, 3, 3);
    tv[16] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 4, 3);
    // reset while holding 0xAA on B
    tv[17] = mkv(0, 1, 8'hAA, 1, 0, 1, 0,  1, 0, 0, 8'h00, 8'h00, 0, 4, 3);
    tv[18] = mkv(0, 0, 8'h00, 0, 0, 1, 0,  0, 0, 1, 8'h00, 8'hAA, 1, 4, 3);
    tv[19] = mkv(1, 0, 8'h00, 0, 0, 1, 1,  0, 0, 0, 8'h00, 8'h00, 0, 4, 3);
    tv[20] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    // mode switch to tag while holding a round-robin word
    tv[21] = mkv(0, 1, 8'h31, 1, 1, 0, 1,  1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tv[22] = mkv(0, 1, 8'h32, 1, 0, 0, 1,  0, 1, 0, 8'h31, 8'h00, 0, 0, 0);
    tv[23] = mkv(0, 1, 8'h32, 1, 0, 1, 1,  1, 1, 0, 8'h31, 8'h00, 0, 0, 0);
    // rr_ptr still 1 after the tag acceptance, so this round-robin word goes to B
    tv[24] = mkv(0, 1, 8'h33, 0, 1, 1, 1,  1, 0, 1, 8'h00, 8'h32, 1, 1, 0);
    tv[25] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 1, 8'h00, 8'h33, 1, 1, 1);
    tv[26] = mkv(0, 0, 8'h00, 0, 0, 1, 1,  1, 0, 0, 8'h00, 8'h00, 0, 1, 2);

    rst = 1'b1; i = '0; i_valid = 1'b0; i_dest = 1'b0; mode = 1'b0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 27; k++) begin
      drive(tv[k]);
      @(negedge clk);
      check($sformatf("vec%0d", k), tv[k]);
      @(posedge clk); #1;
    end

    // Streaming 17 words to B at full rate; the 4-bit counter wraps to 1.
    rst = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b1; i_dest = 1'b1; mode = 1'b0;
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      vec_t v;
      i = 8'(k + 1);
      @(negedge clk);
      v = mkv(0, 1, 8'(k + 1), 1, 0, 1, 1, 1, 0, (k > 0), 8'h00,
              (k > 0) ? 8'(k) : 8'h00, (k > 0), 16'd0,
              (k > 0) ? 16'(k - 1) : 16'd0);
      check($sformatf("stream%0d", k), v);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("stream_last", mkv(0, 0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 8'h00, 8'h11,
                             1, 16'd0, 16'd16));
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap", mkv(0, 0, 8'h00, 1, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00,
                      0, 16'd0, 16'd17));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
